// File: rtl/bridge_mmio_hs_pkg.sv
// -----------------------------------------------------------------------------
// bridge_mmio_hs_pkg
// Shared definitions for the CPU-to-peripheral handshake bridge:
//   - FSM state encoding
//   - the MMIO page (upper 20 address bits of the peripheral window)
//   - slot numbers of the standard SoC peripherals and the slot count they need
//   - default read data returned on a bus error
//   - helper that sizes the shared wait/latency counter
// -----------------------------------------------------------------------------
package bridge_mmio_hs_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_DRAM_WAIT = 2'd1,
      ST_PERI_WAIT = 2'd2,
      ST_RESP      = 2'd3
   } state_t;

   // Peripheral window: 0xFFFFF000 .. 0xFFFFFFFF, 16 bytes per slot.
   localparam logic [19:0] PERI_PAGE = 20'hFFFFF;
   localparam int          SLOT_W    = 8;

   // Standard SoC peripheral slots. A SoC carrying all of them instantiates
   // the bridge with N_PERI = N_PERI_SOC.
   localparam int SLOT_DIG   = 0;
   localparam int SLOT_LED   = 6;
   localparam int SLOT_SW    = 7;
   localparam int SLOT_BTN   = 8;
   localparam int N_PERI_SOC = SLOT_BTN + 1;

   localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hFFFF_FFFF;

   // One counter serves both the DRAM latency countdown and the peripheral
   // timeout count, so it must hold the larger of the two limits.
   function automatic int cnt_width(input int timeout, input int dram_lat);
      int limit;
      limit = (timeout > dram_lat) ? timeout : dram_lat;
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/bridge_addr_decode.sv
// -----------------------------------------------------------------------------
// bridge_addr_decode
// Purely combinational address decoder for the MMIO bridge. Everything outside
// the peripheral page goes to DRAM; inside the page, addr[11:4] picks a slot,
// which is only valid below N_PERI. addr[3:0] never affects the decision.
//
// Ports:
//   addr      in   32      byte address
//   is_dram   out  1       address targets DRAM
//   is_peri   out  1       address targets a populated peripheral slot
//   slot_idx  out  SLOT_W  slot number (meaningful when is_peri=1)
//   unmapped  out  1       address is in the peripheral page but no slot exists
// -----------------------------------------------------------------------------
module bridge_addr_decode
   import bridge_mmio_hs_pkg::*;
#(
   parameter int N_PERI = 4
) (
   input  logic [31:0]       addr,
   output logic              is_dram,
   output logic              is_peri,
   output logic [SLOT_W-1:0] slot_idx,
   output logic              unmapped
);

   logic in_page;
   logic slot_ok;
   logic unused_low_bits;

   assign in_page  = (addr[31:12] == PERI_PAGE);
   assign slot_idx = addr[11:4];
   // One extra bit so that N_PERI = 256 compares correctly.
   assign slot_ok  = ({1'b0, addr[11:4]} < 9'(N_PERI));

   assign is_dram  = !in_page;
   assign is_peri  = in_page && slot_ok;
   assign unmapped = in_page && !slot_ok;

   assign unused_low_bits = ^addr[3:0];

endmodule

// File: rtl/bridge_mmio_hs.sv
// -----------------------------------------------------------------------------
// bridge_mmio_hs
// Request/ready bridge between the CPU load/store unit, DRAM and N_PERI MMIO
// peripheral slots. One transaction is outstanding at a time:
//   IDLE      -> accept req, latch address/enables/data and the decoded target
//   DRAM_WAIT -> DRAM_LAT cycles; byte enables only in the first one, read
//                data captured in the last one
//   PERI_WAIT -> slot selected until its ready, or bus error after TIMEOUT
//   RESP      -> one-cycle ready pulse to the CPU
// Unmapped addresses go straight to RESP with an error.
//
// Ports:
//   clk_from_cpu     in   1          clock, rising edge
//   rst_from_cpu     in   1          asynchronous active-low reset
//   req_from_cpu     in   1          request, only looked at in IDLE
//   addr_from_cpu    in   32         byte address
//   we_from_cpu      in   4          byte write enables (0 = read)
//   wdata_from_cpu   in   32         write data
//   rdata_to_cpu     out  32         read data, sample with ready_to_cpu
//   ready_to_cpu     out  1          one-cycle completion pulse
//   err_to_cpu       out  1          bus error, sample with ready_to_cpu
//   addr_to_dram     out  32         latched address
//   we_to_dram       out  4          byte enables, first DRAM cycle only
//   wdata_to_dram    out  32         latched write data
//   rdata_from_dram  in   32         DRAM read data
//   sel_to_peri      out  N_PERI     one-hot slot select
//   addr_to_peri     out  32         latched address
//   we_to_peri       out  4*N_PERI   per-slot byte enables
//   wdata_to_peri    out  32         latched write data
//   rdata_from_peri  in   32*N_PERI  per-slot read data
//   ready_from_peri  in   N_PERI     per-slot access complete
// -----------------------------------------------------------------------------
module bridge_mmio_hs
   import bridge_mmio_hs_pkg::*;
#(
   parameter int          N_PERI    = 4,
   parameter int          DRAM_LAT  = 1,
   parameter int          TIMEOUT   = 64,
   parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
   input  logic                  clk_from_cpu,
   input  logic                  rst_from_cpu,
   input  logic                  req_from_cpu,
   input  logic [31:0]           addr_from_cpu,
   input  logic [3:0]            we_from_cpu,
   input  logic [31:0]           wdata_from_cpu,
   output logic [31:0]           rdata_to_cpu,
   output logic                  ready_to_cpu,
   output logic                  err_to_cpu,
   output logic [31:0]           addr_to_dram,
   output logic [3:0]            we_to_dram,
   output logic [31:0]           wdata_to_dram,
   input  logic [31:0]           rdata_from_dram,
   output logic [N_PERI-1:0]     sel_to_peri,
   output logic [31:0]           addr_to_peri,
   output logic [4*N_PERI-1:0]   we_to_peri,
   output logic [31:0]           wdata_to_peri,
   input  logic [32*N_PERI-1:0]  rdata_from_peri,
   input  logic [N_PERI-1:0]     ready_from_peri
);

   localparam int             CNT_W       = cnt_width(TIMEOUT, DRAM_LAT);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] DRAM_LOAD   = CNT_W'(DRAM_LAT);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [31:0]       addr_reg, addr_next;
   logic [3:0]        we_reg, we_next;
   logic [31:0]       wdata_reg, wdata_next;
   logic [SLOT_W-1:0] slot_reg, slot_next;
   logic [31:0]       rdata_reg, rdata_next;
   logic              err_reg, err_next;

   logic              dec_is_dram;
   logic              dec_is_peri;
   logic [SLOT_W-1:0] dec_slot;
   logic              dec_unmapped;

   logic [N_PERI-1:0] slot_hit;
   logic              in_peri;
   logic              peri_ready;
   logic [31:0]       peri_rdata;
   logic [CNT_W-1:0]  cnt_inc;

   // ---------------------------------------------------------------- decode
   bridge_addr_decode #(
      .N_PERI (N_PERI)
   ) u_decode (
      .addr     (addr_from_cpu),
      .is_dram  (dec_is_dram),
      .is_peri  (dec_is_peri),
      .slot_idx (dec_slot),
      .unmapped (dec_unmapped)
   );

   // ------------------------------------------------------ slot steering
   assign in_peri = (state_reg == ST_PERI_WAIT);

   genvar gi;
   generate
      for (gi = 0; gi < N_PERI; gi++) begin : g_slot
         assign slot_hit[gi]            = (slot_reg == SLOT_W'(gi));
         assign sel_to_peri[gi]         = in_peri && slot_hit[gi];
         assign we_to_peri[4*gi +: 4]   = (in_peri && slot_hit[gi]) ? we_reg : 4'b0000;
      end
   endgenerate

   // Only the latched slot's handshake and data are looked at; the other
   // slots may toggle ready freely.
   assign peri_ready = |(ready_from_peri & slot_hit);

   always_comb begin
      peri_rdata = '0;
      for (int i = 0; i < N_PERI; i++) begin
         if (slot_hit[i]) begin
            peri_rdata = rdata_from_peri[32*i +: 32];
         end
      end
   end

   // Timeout counter never wraps, so a long stall cannot fall back below
   // the limit.
   assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;

   // ------------------------------------------------------- FSM next state
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      addr_next  = addr_reg;
      we_next    = we_reg;
      wdata_next = wdata_reg;
      slot_next  = slot_reg;
      rdata_next = rdata_reg;
      err_next   = err_reg;

      case (state_reg)
         ST_IDLE: begin
            if (req_from_cpu) begin
               addr_next  = addr_from_cpu;
               we_next    = we_from_cpu;
               wdata_next = wdata_from_cpu;
               slot_next  = dec_slot;
               if (dec_is_dram) begin
                  state_next = ST_DRAM_WAIT;
                  cnt_next   = DRAM_LOAD;
               end else if (dec_is_peri) begin
                  state_next = ST_PERI_WAIT;
                  cnt_next   = '0;
               end else if (dec_unmapped) begin
                  state_next = ST_RESP;
                  rdata_next = ERR_RDATA;
                  err_next   = 1'b1;
               end
            end
         end

         ST_DRAM_WAIT: begin
            // Counter counts down the remaining DRAM cycles; the cycle where
            // it reads 1 is the sampling cycle.
            if (cnt_reg <= CNT_ONE) begin
               state_next = ST_RESP;
               cnt_next   = '0;
               rdata_next = rdata_from_dram;
               err_next   = 1'b0;
            end else begin
               cnt_next = cnt_reg - CNT_ONE;
            end
         end

         ST_PERI_WAIT: begin
            // Ready is checked first so it wins over a coincident timeout.
            if (peri_ready) begin
               state_next = ST_RESP;
               rdata_next = peri_rdata;
               err_next   = 1'b0;
            end else if (cnt_inc >= TIMEOUT_CNT) begin
               state_next = ST_RESP;
               cnt_next   = cnt_inc;
               rdata_next = ERR_RDATA;
               err_next   = 1'b1;
            end else begin
               cnt_next = cnt_inc;
            end
         end

         ST_RESP: begin
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------- state register
   always_ff @(posedge clk_from_cpu or negedge rst_from_cpu) begin
      if (!rst_from_cpu) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         addr_reg  <= '0;
         we_reg    <= '0;
         wdata_reg <= '0;
         slot_reg  <= '0;
         rdata_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         addr_reg  <= addr_next;
         we_reg    <= we_next;
         wdata_reg <= wdata_next;
         slot_reg  <= slot_next;
         rdata_reg <= rdata_next;
         err_reg   <= err_next;
      end
   end

   // ------------------------------------------------------------- outputs
   assign ready_to_cpu  = (state_reg == ST_RESP);
   assign rdata_to_cpu  = rdata_reg;
   assign err_to_cpu    = err_reg;

   assign addr_to_dram  = addr_reg;
   assign wdata_to_dram = wdata_reg;
   // The counter still holds its load value only in the first DRAM cycle,
   // which is the one cycle the write strobe is presented.
   assign we_to_dram    = ((state_reg == ST_DRAM_WAIT) && (cnt_reg == DRAM_LOAD)) ? we_reg : 4'b0000;

   assign addr_to_peri  = addr_reg;
   assign wdata_to_peri = wdata_reg;

endmodule

// File: tb/tb_bridge_mmio_hs.sv
module tb_bridge_mmio_hs;

   localparam int          N_PERI     = 4;
   localparam int          DRAM_LAT   = 2;
   localparam int          TIMEOUT    = 8;
   localparam logic [31:0] ERR_WORD   = 32'hFFFF_FFFF;
   localparam int          MAX_CYCLES = 40;

   localparam int K_DRAM = 0;
   localparam int K_PERI = 1;
   localparam int K_UNM  = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 req;
   logic [31:0]          addr;
   logic [3:0]           we;
   logic [31:0]          wdata;
   logic [31:0]          rdata_to_cpu;
   logic                 ready_to_cpu;
   logic                 err_to_cpu;
   logic [31:0]          addr_to_dram;
   logic [3:0]           we_to_dram;
   logic [31:0]          wdata_to_dram;
   logic [31:0]          dram_rdata;
   logic [N_PERI-1:0]    sel_to_peri;
   logic [31:0]          addr_to_peri;
   logic [4*N_PERI-1:0]  we_to_peri;
   logic [31:0]          wdata_to_peri;
   logic [32*N_PERI-1:0] peri_rdata;
   logic [N_PERI-1:0]    peri_ready;

   int n_vectors     = 0;
   int n_miscompares = 0;
   int n_txn         = 0;

   always #5 clk = ~clk;

   bridge_mmio_hs #(
      .N_PERI    (N_PERI),
      .DRAM_LAT  (DRAM_LAT),
      .TIMEOUT   (TIMEOUT),
      .ERR_RDATA (ERR_WORD)
   ) dut (
      .clk_from_cpu    (clk),
      .rst_from_cpu    (rst_n),
      .req_from_cpu    (req),
      .addr_from_cpu   (addr),
      .we_from_cpu     (we),
      .wdata_from_cpu  (wdata),
      .rdata_to_cpu    (rdata_to_cpu),
      .ready_to_cpu    (ready_to_cpu),
      .err_to_cpu      (err_to_cpu),
      .addr_to_dram    (addr_to_dram),
      .we_to_dram      (we_to_dram),
      .wdata_to_dram   (wdata_to_dram),
      .rdata_from_dram (dram_rdata),
      .sel_to_peri     (sel_to_peri),
      .addr_to_peri    (addr_to_peri),
      .we_to_peri      (we_to_peri),
      .wdata_to_peri   (wdata_to_peri),
      .rdata_from_peri (peri_rdata),
      .ready_from_peri (peri_ready)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ready"}, 64'(ready_to_cpu), 0);
      check_eq({tag, "_err"}, 64'(err_to_cpu), 0);
      check_eq({tag, "_rdata"}, 64'(rdata_to_cpu), 0);
      check_eq({tag, "_sel"}, 64'(sel_to_peri), 0);
      check_eq({tag, "_we_peri"}, 64'(we_to_peri), 0);
      check_eq({tag, "_we_dram"}, 64'(we_to_dram), 0);
      check_eq({tag, "_addr"}, 64'({addr_to_dram, addr_to_peri}), 0);
      check_eq({tag, "_wdata"}, 64'({wdata_to_dram, wdata_to_peri}), 0);
   endtask

   // One complete transaction. The bench plays DRAM and the peripherals:
   // the DRAM word is only valid in the cycle it must be sampled, and the
   // target slot raises ready (with its data) in wait cycle pdelay only.
   task automatic do_txn(input logic [31:0] t_addr, input logic [3:0] t_we, input logic [31:0] t_wdata,
                         input logic [31:0] dval, input logic [31:0] pval, input int pdelay,
                         input bit noise_req);
      int          kind;
      int          slot;
      int          exp_lat;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          got_lat;
      logic [31:0] got_rd;
      logic        got_err;
      int          bus_bad;
      logic [N_PERI-1:0]   exp_sel;
      logic [4*N_PERI-1:0] exp_wep;
      logic [3:0]          exp_wed;
      bit          done;

      // Reference: decode and outcome from the address map rules.
      slot = int'(t_addr[11:4]);
      if (t_addr[31:12] != 20'hFFFFF) begin
         kind = K_DRAM; exp_lat = DRAM_LAT + 1; exp_rd = dval; exp_err = 1'b0;
      end else if (slot < N_PERI) begin
         kind = K_PERI;
         if (pdelay <= TIMEOUT) begin
            exp_lat = pdelay + 1; exp_rd = pval; exp_err = 1'b0;
         end else begin
            exp_lat = TIMEOUT + 1; exp_rd = ERR_WORD; exp_err = 1'b1;
         end
      end else begin
         kind = K_UNM; exp_lat = 1; exp_rd = ERR_WORD; exp_err = 1'b1;
      end

      @(posedge clk); #1;
      req = 1'b1; addr = t_addr; we = t_we; wdata = t_wdata; peri_ready = '0;
      @(posedge clk);   // accepting edge

      got_lat = 0; got_rd = '0; got_err = 1'b0; bus_bad = 0; done = 1'b0;
      for (int c = 1; c <= MAX_CYCLES && !done; c++) begin
         #1;
         req   = noise_req ? 1'($urandom_range(0, 1)) : 1'b0;
         addr  = $urandom;
         we    = 4'($urandom);
         wdata = $urandom;
         dram_rdata = (c == DRAM_LAT) ? dval : $urandom;
         for (int s = 0; s < N_PERI; s++) begin
            peri_rdata[32*s +: 32] = $urandom;
            peri_ready[s] = 1'($urandom_range(0, 1));
         end
         if (kind == K_PERI) begin
            peri_ready[slot] = (c == pdelay);
            if (c == pdelay) peri_rdata[32*slot +: 32] = pval;
         end

         @(negedge clk);
         exp_sel = '0; exp_wep = '0; exp_wed = '0;
         if (kind == K_PERI && c < exp_lat) begin
            exp_sel = N_PERI'(1) << slot;
            exp_wep = (4*N_PERI)'(t_we) << (4 * slot);
         end
         if (kind == K_DRAM && c == 1) exp_wed = t_we;
         if (sel_to_peri !== exp_sel || we_to_peri !== exp_wep || we_to_dram !== exp_wed) bus_bad++;
         if (c < exp_lat && (addr_to_dram !== t_addr || addr_to_peri !== t_addr ||
                             wdata_to_dram !== t_wdata || wdata_to_peri !== t_wdata)) bus_bad++;
         if (ready_to_cpu) begin
            got_lat = c; got_rd = rdata_to_cpu; got_err = err_to_cpu; done = 1'b1;
         end
         @(posedge clk);
      end

      #1;
      req = 1'b0; peri_ready = '0;
      @(negedge clk);
      check_eq("latency", 64'(got_lat), 64'(exp_lat));
      check_eq("rdata", 64'(got_rd), 64'(exp_rd));
      check_eq("err", 64'(got_err), 64'(exp_err));
      check_eq("bus", 64'(bus_bad), 0);
      check_eq("ready_pulse", 64'(ready_to_cpu), 0);
      check_eq("resp_hold", 64'({err_to_cpu, rdata_to_cpu}), 64'({exp_err, exp_rd}));
      n_txn++;
      $display("txn %0d addr=%08h we=%h lat=%0d/%0d rdata=%08h err=%0b", n_txn, t_addr, t_we,
               got_lat, exp_lat, got_rd, got_err);
   endtask

   initial begin
      logic [31:0] a;
      int          pick;
      int          sl;

      rst_n = 1'b0; req = 1'b0; addr = '0; we = '0; wdata = '0;
      dram_rdata = '0; peri_rdata = '0; peri_ready = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases from the test plan.
      do_txn(32'h0000_0100, 4'b0000, 32'h0, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
      do_txn(32'h0000_0040, 4'b0011, 32'h1234_5678, 32'h0BAD_F00D, 32'h0, 0, 1'b0);
      do_txn(32'hFFFF_F010, 4'b0000, 32'h0, 32'h0, 32'h0000_00A5, 5, 1'b0);
      do_txn(32'hFFFF_F000, 4'b0000, 32'h0, 32'h0, 32'h0000_0077, 100, 1'b0);
      do_txn(32'hFFFF_F000, 4'b0000, 32'h0, 32'h0, 32'h0000_005A, TIMEOUT, 1'b0);
      do_txn(32'hFFFF_F00C, 4'b1111, 32'hCAFE_0001, 32'h0, 32'h0000_0033, TIMEOUT + 1, 1'b0);
      do_txn(32'hFFFF_F0F0, 4'b1111, 32'h5555_AAAA, 32'h0, 32'h0, 1, 1'b0);

      // Reset in the middle of a peripheral wait.
      @(posedge clk); #1;
      req = 1'b1; addr = 32'hFFFF_F020; we = 4'b1111; wdata = 32'h0F0F_0F0F; peri_ready = '0;
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      check_eq("mid_sel", 64'(sel_to_peri), 64'(4'b0100));
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      repeat (3) begin
         @(negedge clk);
         check_eq("reset_no_ready", 64'(ready_to_cpu), 0);
      end
      rst_n = 1'b1;
      do_txn(32'hFFFF_F020, 4'b0000, 32'h0, 32'h0, 32'h1357_9BDF, 3, 1'b0);
      do_txn(32'h0000_2000, 4'b0000, 32'h0, 32'h2468_ACE0, 32'h0, 0, 1'b1);

      // Randomized traffic.
      for (int n = 0; n < 150; n++) begin
         pick = $urandom_range(0, 99);
         a = $urandom;
         if (pick < 50) begin
            if (a[31:12] == 20'hFFFFF) a[31] = 1'b0;
         end else if (pick < 85) begin
            sl = $urandom_range(0, N_PERI - 1);
            a = {20'hFFFFF, 8'(sl), a[3:0]};
         end else begin
            sl = $urandom_range(N_PERI, 255);
            a = {20'hFFFFF, 8'(sl), a[3:0]};
         end
         do_txn(a, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0000, $urandom,
                $urandom, $urandom, $urandom_range(1, TIMEOUT + 2), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule

// File: doc/bridge_mmio_hs.md
Name: bridge_mmio_hs

Overview:
- Next-generation CPU-to-peripheral bridge for the pipelined core.
- Replaces single-cycle combinational steering with a request/ready handshake:
  - one outstanding transaction;
  - configurable DRAM latency;
  - N parametrised peripheral slots with per-slot wait states (ready_from_peri);
  - bus-error on unmapped addresses or peripheral timeout.
- Sits between the CPU load/store unit, the DRAM and the MMIO peripherals (dig, led, sw, btn, and future slots).

Parameters:
- N_PERI, 4, number of peripheral slots (1..256); slot i occupies 0xFFFFF000 + 16*i.
- DRAM_LAT, 1, cycles from issue to DRAM rdata sampling (1..15).
- TIMEOUT, 64, max PERI_WAIT cycles before bus error (>=1).
- ERR_RDATA, 32'hFFFF_FFFF, read data returned on error.

Ports:
- clk_from_cpu  in  1  single clock, rising edge.
- rst_from_cpu  in  1  asynchronous, active-low reset.
- req_from_cpu  in  1  request valid; sampled only in IDLE.
- addr_from_cpu  in  32  byte address.
- we_from_cpu  in  4  byte write enables; 0 = read.
- wdata_from_cpu  in  32  write data.
- rdata_to_cpu  out  32  read data, valid while ready_to_cpu=1.
- ready_to_cpu  out  1  one-cycle completion pulse.
- err_to_cpu  out  1  bus error, qualified by ready_to_cpu.
- addr_to_dram  out  32  latched address.
- we_to_dram  out  4  byte enables.
- wdata_to_dram  out  32  latched write data.
- rdata_from_dram  in  32  DRAM read data.
- sel_to_peri  out  N_PERI  one-hot slot select.
- addr_to_peri  out  32  latched address.
- we_to_peri  out  4*N_PERI  per-slot byte enables; slot i uses bits [4i+3:4i].
- wdata_to_peri  out  32  latched write data.
- rdata_from_peri  in  32*N_PERI  per-slot read data.
- ready_from_peri  in  N_PERI  per-slot access-complete signal.

Behaviour:
- Reset state: FSM in IDLE.
  - All outputs 0, except addr and wdata, which hold 0.
  - The reset is asynchronous, so it takes effect mid-transaction too: the access is abandoned and no ready is issued.
- Decode, on addr_from_cpu at accept:
  - addr[31:12] != 20'hFFFFF -> DRAM.
  - Otherwise slot = addr[11:4]; the slot is valid if slot < N_PERI.
  - Otherwise the address is unmapped.
  - addr[3:0] is ignored for slot selection.
- IDLE:
  - If req=1: latch addr, we, wdata and target.
  - DRAM target -> DRAM_WAIT, with the counter loaded with DRAM_LAT.
  - Valid slot -> PERI_WAIT, with the counter cleared.
  - Unmapped -> RESP, with err=1 and rdata=ERR_RDATA.
- DRAM_WAIT:
  - addr/wdata_to_dram driven from the latch.
  - we_to_dram = latched we in the first DRAM_WAIT cycle only, 0 afterwards.
  - After DRAM_LAT cycles, capture rdata_from_dram into rdata_to_cpu and go to RESP with err=0.
  - Read latency: ready_to_cpu asserts DRAM_LAT+1 cycles after the accepting edge.
- PERI_WAIT:
  - sel_to_peri[slot]=1, and we_to_peri slot bits = latched we, both held every cycle until exit.
  - If ready_from_peri[slot]=1: capture rdata_from_peri slot word, err=0, go to RESP.
  - Else increment the counter; when it reaches TIMEOUT, go to RESP with err=1 and rdata=ERR_RDATA.
  - If ready and timeout occur in the same cycle, ready wins.
  - ready_from_peri of unselected slots is ignored.
- RESP:
  - ready_to_cpu=1 for exactly one cycle.
  - sel and we are 0.
  - Return to IDLE.
  - rdata_to_cpu and err_to_cpu hold until the next RESP; the CPU must sample them at ready.
- Timing and interlocks:
  - req is ignored outside IDLE; the CPU must hold or re-issue it.
  - Minimum back-to-back period is DRAM_LAT+2 cycles.
  - Writes return rdata = captured target data; the CPU must not rely on it.
- Counter width: $clog2(max(TIMEOUT, DRAM_LAT)+1). It saturates and never wraps.

Decomposition:
- Shared defines header / package:
  - FSM state encoding (IDLE, DRAM_WAIT, PERI_WAIT, RESP);
  - PERI_PAGE 20'hFFFFF;
  - slot numbers for DIG=0, LED=6, SW=7, BTN=8, with N_PERI set accordingly;
  - ERR_RDATA default.
- One sub-module, bridge_addr_decode:
  - combinational: addr -> {is_dram, is_peri, slot_idx, unmapped}, parametrised by N_PERI;
  - reused by the future cache-bypass logic.

Test Plan:
1. Read with DRAM_LAT=2: req at 0x0000_0100, we=0, DRAM returns 0xDEADBEEF -> ready at the 3rd edge after accept, rdata=0xDEADBEEF, err=0.
2. DRAM write: addr 0x40, we=4'b0011, wdata 0x1234_5678 -> we_to_dram=0011 for exactly one cycle, wdata_to_dram=0x12345678, then ready.
3. Peripheral slot 1 (0xFFFFF010) read, with ready_from_peri[1] asserted after 5 cycles and data 0x0000_00A5 -> sel_to_peri=0b0010 held for 5 cycles, then ready, rdata=0xA5, err=0.
4. Timeout: TIMEOUT=8, slot 0 access, ready_from_peri held 0 -> ready 9 cycles after accept, err=1, rdata=0xFFFFFFFF. Repeat with ready arriving in the timeout cycle -> err=0.
5. Unmapped access (N_PERI=4, addr 0xFFFFF0F0) -> ready one cycle after accept, err=1, rdata=0xFFFFFFFF, no sel or we asserted.
6. Reset and busy interlock:
   - reset asserted during PERI_WAIT -> all outputs 0 immediately, no ready; first req after release is serviced normally;
   - req pulses during DRAM_WAIT -> no effect.
